clk_div_bank: RTL and testbench

- Multi-channel, runtime-programmable clock divider. Generates CHANNELS independent 50%-duty divided clocks from clk_in.
- Each channel also provides a one-cycle rising-edge tick and a per-channel reset-release flag.
- Half-period updates are glitch-free: a new value is shadowed and applied at the next phase boundary.
- Sits beside the top-level clock logic and feeds slow timing domains (game tick, display refresh, debounce).

---
 rtl/clk_div_bank.sv | 113 +++++++++++
 tb/tb_clk_div_bank.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/clk_div_bank.sv
// Bank of independent runtime-programmable 50%-duty clock dividers with rising-edge ticks,
// per-channel reset-release flags and shadowed half-period updates applied at phase boundaries.
module clk_div_bank #(
  parameter int CHANNELS     = 2,
  parameter int CNT_WIDTH    = 20,
  parameter int DEFAULT_HALF = 500_000,
  parameter int CH_W         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                 clk_in,
  input  logic                 rst_n,
  input  logic [CHANNELS-1:0]  en,
  input  logic                 sync,
  input  logic                 cfg_we,
  input  logic [CH_W-1:0]      cfg_ch,
  input  logic [CNT_WIDTH-1:0] cfg_half,
  output logic [CHANNELS-1:0]  cfg_pending,
  output logic [CHANNELS-1:0]  clk_div,
  output logic [CHANNELS-1:0]  tick,
  output logic [CHANNELS-1:0]  rst_d
);

  localparam logic [CNT_WIDTH-1:0] HALF_RST = CNT_WIDTH'(DEFAULT_HALF);
  localparam logic [CNT_WIDTH-1:0] ONE      = CNT_WIDTH'(1);

  logic [CNT_WIDTH-1:0] cnt_q    [CHANNELS];
  logic [CNT_WIDTH-1:0] cnt_d    [CHANNELS];
  logic [CNT_WIDTH-1:0] half_q   [CHANNELS];
  logic [CNT_WIDTH-1:0] half_d   [CHANNELS];
  logic [CNT_WIDTH-1:0] shadow_q [CHANNELS];
  logic [CNT_WIDTH-1:0] shadow_d [CHANNELS];

  logic [CHANNELS-1:0] clk_q, clk_d;
  logic [CHANNELS-1:0] tick_q, tick_d;
  logic [CHANNELS-1:0] rstd_q, rstd_d;
  logic [CHANNELS-1:0] pend_q, pend_d;
  logic [CHANNELS-1:0] wr_hit, wrap, restart;
  logic [CNT_WIDTH-1:0] wr_val;

  // A zero half-period would never wrap, so it is clamped to the fastest legal setting.
  assign wr_val = (cfg_half == '0) ? ONE : cfg_half;

  always_comb begin
    wr_hit  = '0;
    wrap    = '0;
    restart = '0;
    clk_d   = clk_q;
    tick_d  = '0;
    rstd_d  = rstd_q & ~clk_q;
    pend_d  = pend_q;
    for (int i = 0; i < CHANNELS; i++) begin
      cnt_d[i]    = cnt_q[i] + ONE;
      half_d[i]   = half_q[i];
      shadow_d[i] = shadow_q[i];

      wr_hit[i]  = cfg_we && (cfg_ch == CH_W'(i));
      restart[i] = sync || !en[i];
      wrap[i]    = en[i] && (cnt_q[i] == half_q[i] - ONE);

      if (restart[i]) begin
        cnt_d[i] = '0;
        clk_d[i] = 1'b0;
      end else if (wrap[i]) begin
        cnt_d[i]  = '0;
        clk_d[i]  = ~clk_q[i];
        tick_d[i] = ~clk_q[i];
      end

      // Phase boundary: a same-cycle write bypasses the shadow, otherwise a pending value lands.
      if (restart[i] || wrap[i]) begin
        pend_d[i] = 1'b0;
        if (wr_hit[i]) begin
          half_d[i]   = wr_val;
          shadow_d[i] = wr_val;
        end else if (pend_q[i]) begin
          half_d[i] = shadow_q[i];
        end
      end else if (wr_hit[i]) begin
        shadow_d[i] = wr_val;
        pend_d[i]   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i]    <= '0;
        half_q[i]   <= HALF_RST;
        shadow_q[i] <= HALF_RST;
      end
      clk_q  <= '0;
      tick_q <= '0;
      rstd_q <= '1;
      pend_q <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i]    <= cnt_d[i];
        half_q[i]   <= half_d[i];
        shadow_q[i] <= shadow_d[i];
      end
      clk_q  <= clk_d;
      tick_q <= tick_d;
      rstd_q <= rstd_d;
      pend_q <= pend_d;
    end
  end

  assign clk_div     = clk_q;
  assign tick        = tick_q;
  assign rst_d       = rstd_q;
  assign cfg_pending = pend_q;

endmodule

// File: tb/tb_clk_div_bank.sv
// Directed bench for clk_div_bank: two channels, 8-bit counters, default half-period 4.
// The channel select is widened to 3 bits so out-of-range channel writes can be driven.
module tb_clk_div_bank;

  logic       clk_in;
  logic       rst_n;
  logic [1:0] en;
  logic       sync;
  logic       cfg_we;
  logic [2:0] cfg_ch;
  logic [7:0] cfg_half;
  logic [1:0] cfg_pending;
  logic [1:0] clk_div;
  logic [1:0] tick;
  logic [1:0] rst_d;

  int n_chk = 0;
  int n_bad = 0;

  clk_div_bank #(
    .CHANNELS    (2),
    .CNT_WIDTH   (8),
    .DEFAULT_HALF(4),
    .CH_W        (3)
  ) dut (
    .clk_in     (clk_in),
    .rst_n      (rst_n),
    .en         (en),
    .sync       (sync),
    .cfg_we     (cfg_we),
    .cfg_ch     (cfg_ch),
    .cfg_half   (cfg_half),
    .cfg_pending(cfg_pending),
    .clk_div    (clk_div),
    .tick       (tick),
    .rst_d      (rst_d)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Free-running from a reset release with default half 4: rise on edge 4, period 8.
  task automatic run_default(input string tag, input int n);
    for (int k = 1; k <= n; k++) begin
      @(posedge clk_in); #1;
      chk($sformatf("%s_clk_e%0d", tag, k), clk_div, (((k / 4) % 2) == 1) ? 2'b11 : 2'b00);
      chk($sformatf("%s_tick_e%0d", tag, k), tick, ((k % 8) == 4) ? 2'b11 : 2'b00);
      chk($sformatf("%s_rstd_e%0d", tag, k), rst_d, (k >= 5) ? 2'b00 : 2'b11);
      chk($sformatf("%s_pend_e%0d", tag, k), cfg_pending, 2'b00);
    end
  endtask

  // Drive one cycle of inputs, then check outputs just after the following edge.
  task automatic vec(input int e, input logic [1:0] v_en, input logic v_sync, input logic v_we,
                     input logic [2:0] v_ch, input logic [7:0] v_half,
                     input logic [1:0] x_clk, input logic [1:0] x_tick, input logic [1:0] x_pend);
    en       = v_en;
    sync     = v_sync;
    cfg_we   = v_we;
    cfg_ch   = v_ch;
    cfg_half = v_half;
    @(posedge clk_in); #1;
    chk($sformatf("clk_e%0d", e), clk_div, x_clk);
    chk($sformatf("tick_e%0d", e), tick, x_tick);
    chk($sformatf("pend_e%0d", e), cfg_pending, x_pend);
    chk($sformatf("rstd_e%0d", e), rst_d, 2'b00);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b1; en = 2'b00; sync = 1'b0;
    cfg_we = 1'b0; cfg_ch = 3'd0; cfg_half = 8'd0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_clk", clk_div, 2'b00);
    chk("rst_tick", tick, 2'b00);
    chk("rst_rstd", rst_d, 2'b11);
    chk("rst_pend", cfg_pending, 2'b00);
    en = 2'b11;
    repeat (2) @(posedge clk_in);
    #3 rst_n = 1'b1;

    // Edges 1..21 after release.
    run_default("s1", 21);

    // Ch0 reprogrammed to 2 mid high phase; applied at the edge-24 boundary.
    vec(22, 2'b11, 0, 1, 3'd0, 8'd2, 2'b11, 2'b00, 2'b01);
    vec(23, 2'b11, 0, 0, 3'd0, 8'd0, 2'b11, 2'b00, 2'b01);
    vec(24, 2'b11, 0, 0, 3'd0, 8'd0, 2'b00, 2'b00, 2'b00);
    vec(25, 2'b11, 0, 0, 3'd0, 8'd0, 2'b00, 2'b00, 2'b00);
    vec(26, 2'b11, 0, 0, 3'd0, 8'd0, 2'b01, 2'b01, 2'b00);
    vec(27, 2'b11, 0, 0, 3'd0, 8'd0, 2'b01, 2'b00, 2'b00);
    vec(28, 2'b11, 0, 0, 3'd0, 8'd0, 2'b10, 2'b10, 2'b00);
    vec(29, 2'b11, 0, 0, 3'd0, 8'd0, 2'b10, 2'b00, 2'b00);
    vec(30, 2'b11, 0, 0, 3'd0, 8'd0, 2'b11, 2'b01, 2'b00);
    vec(31, 2'b11, 0, 0, 3'd0, 8'd0, 2'b11, 2'b00, 2'b00);
    vec(32, 2'b11, 0, 0, 3'd0, 8'd0, 2'b00, 2'b00, 2'b00);

    // Ch1 written with 0 (clamps to 1); applied at its edge-36 rise.
    vec(33, 2'b11, 0, 1, 3'd1, 8'd0, 2'b00, 2'b00, 2'b10);
    vec(34, 2'b11, 0, 0, 3'd0, 8'd0, 2'b01, 2'b01, 2'b10);
    vec(35, 2'b11, 0, 0, 3'd0, 8'd0, 2'b01, 2'b00, 2'b10);
    vec(36, 2'b11, 0, 0, 3'd0, 8'd0, 2'b10, 2'b10, 2'b00);
    vec(37, 2'b11, 0, 0, 3'd0, 8'd0, 2'b00, 2'b00, 2'b00);
    vec(38, 2'b11, 0, 0, 3'd0, 8'd0, 2'b11, 2'b11, 2'b00);
    vec(39, 2'b11, 0, 0, 3'd0, 8'd0, 2'b01, 2'b00, 2'b00);
    vec(40, 2'b11, 0, 0, 3'd0, 8'd0, 2'b10, 2'b10, 2'b00);

    // Ch1 disabled with a same-cycle write of 4 (direct apply), then ch5 writes held throughout.
    vec(41, 2'b01, 0, 1, 3'd1, 8'd4, 2'b00, 2'b00, 2'b00);
    vec(42, 2'b01, 0, 1, 3'd5, 8'd9, 2'b01, 2'b01, 2'b00);
    vec(43, 2'b11, 0, 1, 3'd5, 8'd9, 2'b01, 2'b00, 2'b00);
    vec(44, 2'b11, 0, 1, 3'd5, 8'd9, 2'b00, 2'b00, 2'b00);
    vec(45, 2'b11, 0, 1, 3'd5, 8'd9, 2'b00, 2'b00, 2'b00);
    vec(46, 2'b11, 0, 1, 3'd5, 8'd9, 2'b11, 2'b11, 2'b00);
    vec(47, 2'b11, 0, 1, 3'd5, 8'd9, 2'b11, 2'b00, 2'b00);
    vec(48, 2'b01, 0, 1, 3'd5, 8'd9, 2'b00, 2'b00, 2'b00);
    vec(49, 2'b11, 0, 1, 3'd5, 8'd9, 2'b00, 2'b00, 2'b00);
    vec(50, 2'b11, 0, 1, 3'd5, 8'd9, 2'b01, 2'b01, 2'b00);
    vec(51, 2'b11, 0, 1, 3'd5, 8'd9, 2'b01, 2'b00, 2'b00);
    vec(52, 2'b11, 0, 0, 3'd0, 8'd0, 2'b10, 2'b10, 2'b00);

    // Both off (ch0 set back to 4 directly), re-enabled 3 cycles apart, then a sync pulse.
    vec(53, 2'b00, 0, 1, 3'd0, 8'd4, 2'b00, 2'b00, 2'b00);
    vec(54, 2'b01, 0, 0, 3'd0, 8'd0, 2'b00, 2'b00, 2'b00);
    vec(55, 2'b01, 0, 0, 3'd0, 8'd0, 2'b00, 2'b00, 2'b00);
    vec(56, 2'b01, 0, 0, 3'd0, 8'd0, 2'b00, 2'b00, 2'b00);
    vec(57, 2'b11, 0, 0, 3'd0, 8'd0, 2'b01, 2'b01, 2'b00);
    vec(58, 2'b11, 0, 0, 3'd0, 8'd0, 2'b01, 2'b00, 2'b00);
    vec(59, 2'b11, 0, 0, 3'd0, 8'd0, 2'b01, 2'b00, 2'b00);
    vec(60, 2'b11, 0, 0, 3'd0, 8'd0, 2'b11, 2'b10, 2'b00);
    vec(61, 2'b11, 0, 0, 3'd0, 8'd0, 2'b10, 2'b00, 2'b00);
    vec(62, 2'b11, 0, 0, 3'd0, 8'd0, 2'b10, 2'b00, 2'b00);
    vec(63, 2'b11, 1, 0, 3'd0, 8'd0, 2'b00, 2'b00, 2'b00);
    vec(64, 2'b11, 0, 0, 3'd0, 8'd0, 2'b00, 2'b00, 2'b00);
    vec(65, 2'b11, 0, 0, 3'd0, 8'd0, 2'b00, 2'b00, 2'b00);
    vec(66, 2'b11, 0, 0, 3'd0, 8'd0, 2'b00, 2'b00, 2'b00);
    vec(67, 2'b11, 0, 0, 3'd0, 8'd0, 2'b11, 2'b11, 2'b00);
    vec(68, 2'b11, 0, 0, 3'd0, 8'd0, 2'b11, 2'b00, 2'b00);

    // Leave ch0 at half 2 and ch1 with a pending 3, then reset mid-phase.
    vec(69, 2'b10, 0, 1, 3'd0, 8'd2, 2'b10, 2'b00, 2'b00);
    vec(70, 2'b11, 0, 1, 3'd1, 8'd3, 2'b10, 2'b00, 2'b10);
    cfg_we = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_clk", clk_div, 2'b00);
    chk("arst_tick", tick, 2'b00);
    chk("arst_rstd", rst_d, 2'b11);
    chk("arst_pend", cfg_pending, 2'b00);
    @(posedge clk_in); #1;
    chk("arst_hold_clk", clk_div, 2'b00);
    chk("arst_hold_rstd", rst_d, 2'b11);
    #2 rst_n = 1'b1;

    run_default("s6", 17);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
